// File: rtl/ql_membank_cfg_ctrl.sv
// Configuration-memory load controller: streams DW-bit words into a row-wide
// bit-line register, then pulses one word line per row to commit it.
module ql_membank_cfg_ctrl #(
  parameter int unsigned NUM_BL   = 514,
  parameter int unsigned NUM_WL   = 407,
  parameter int unsigned DW       = 32,
  parameter int unsigned WL_PULSE = 2
) (
  input  logic              clk,
  input  logic              global_resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DW-1:0]     s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WPR     = (NUM_BL + DW - 1) / DW;
  localparam int unsigned ROW_W   = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int unsigned WORD_W  = $clog2(WPR + 1);
  localparam int unsigned PULSE_W = 4;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, HOLD, DONE} state_t;

  state_t              state, state_nx;
  logic [ROW_W-1:0]    row;
  logic [WORD_W-1:0]   word;
  logic [PULSE_W-1:0]  pulse_cnt;
  logic                armed;
  logic                accept, restart, next_row;
  logic [0:NUM_WL-1]   wl_nx;
  logic [0:NUM_BL-1]   bl_nx;

  // State register
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) state <= IDLE;
    else                state <= state_nx;
  end

  // Next-state and control strobes; abort wins over everything while busy
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    restart  = 1'b0;
    next_row = 1'b0;
    case (state)
      IDLE: begin
        if (start && armed && !abort) begin
          state_nx = LOAD;
          restart  = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (s_valid && s_ready) begin
          accept = 1'b1;
          if (word == WORD_W'(WPR - 1)) state_nx = WRITE;
        end
      end
      WRITE: begin
        if (abort)                                      state_nx = IDLE;
        else if (pulse_cnt == PULSE_W'(WL_PULSE - 1))   state_nx = HOLD;
      end
      HOLD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (row == ROW_W'(NUM_WL - 1)) begin
          state_nx = DONE;
        end else begin
          state_nx = LOAD;
          next_row = 1'b1;
        end
      end
      DONE: begin
        if (start && armed) begin
          state_nx = LOAD;
          restart  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    wl_nx = '0;
    if (state_nx == WRITE) wl_nx[row] = 1'b1;
  end

  // Each accepted word overwrites only its own bit-line segment; bits past NUM_BL are dropped
  for (genvar i = 0; i < NUM_BL; i++) begin : g_bl
    assign bl_nx[i] = restart ? 1'b0 :
                      (accept && (word == WORD_W'(i / DW))) ? s_data[i % DW] : bl[i];
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      armed     <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wl        <= '0;
      bl        <= '0;
      row       <= '0;
      word      <= '0;
      pulse_cnt <= '0;
    end else begin
      armed     <= 1'b1;
      s_ready   <= (state_nx == LOAD);
      busy      <= (state_nx == LOAD) || (state_nx == WRITE) || (state_nx == HOLD);
      done      <= (state_nx == DONE);
      wl        <= wl_nx;
      bl        <= bl_nx;
      pulse_cnt <= (state == WRITE) ? pulse_cnt + PULSE_W'(1) : '0;
      if (restart) begin
        row  <= '0;
        word <= '0;
      end else if (next_row) begin
        row  <= row + ROW_W'(1);
        word <= '0;
      end else if (accept) begin
        word <= word + WORD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ql_membank_cfg_ctrl.sv
// Bench for ql_membank_cfg_ctrl: randomized bitstream loads checked against a
// row/segment overlay model, plus abort, reset and narrow-row scenarios.
module tb_ql_membank_cfg_ctrl;

  localparam int unsigned NUM_BL   = 514;
  localparam int unsigned NUM_WL   = 407;
  localparam int unsigned DW       = 32;
  localparam int unsigned WL_PULSE = 2;
  localparam int unsigned WPR      = (NUM_BL + DW - 1) / DW;

  localparam int unsigned B_BL = 40;
  localparam int unsigned B_WL = 2;
  localparam int unsigned B_PW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              global_resetn;
  logic              start, abort, s_valid;
  logic [DW-1:0]     s_data;
  logic              s_ready, busy, done;
  logic [0:NUM_BL-1] bl;
  logic [0:NUM_WL-1] wl;

  logic              b_start, b_abort, b_s_valid;
  logic [31:0]       b_s_data;
  logic              b_s_ready, b_busy, b_done;
  logic [0:B_BL-1]   b_bl;
  logic [0:B_WL-1]   b_wl;

  ql_membank_cfg_ctrl #(.NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .DW(DW), .WL_PULSE(WL_PULSE)) dut (
    .clk(clk), .global_resetn(global_resetn), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bl(bl), .wl(wl), .busy(busy), .done(done));

  ql_membank_cfg_ctrl #(.NUM_BL(B_BL), .NUM_WL(B_WL), .DW(32), .WL_PULSE(B_PW)) dut_b (
    .clk(clk), .global_resetn(global_resetn), .start(b_start), .abort(b_abort),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .bl(b_bl), .wl(b_wl), .busy(b_busy), .done(b_done));

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned seed;

  logic [0:NUM_BL-1] exp_bl, saved_bl;
  int acc_in_row, rows_written, pulse_len, total_acc, cycles;
  bit start_injected;

  function automatic logic [DW-1:0] word_of(input int unsigned idx);
    return DW'((idx * 32'h9E3779B9) ^ seed ^ (idx << 7));
  endfunction

  function automatic int wl_index(input logic [0:NUM_WL-1] v);
    for (int i = 0; i < NUM_WL; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    exp_bl = '0; acc_in_row = 0; rows_written = 0; pulse_len = 0; total_acc = 0; cycles = 0;
  endtask

  // Word k of the current row lands on bit lines k*DW .. k*DW+DW-1
  task automatic model_accept(input logic [DW-1:0] w);
    int idx;
    for (int j = 0; j < DW; j++) begin
      idx = acc_in_row * DW + j;
      if (idx < NUM_BL) exp_bl[idx] = w[j];
    end
    acc_in_row++;
    total_acc++;
  endtask

  // Per-cycle check of word-line behaviour against the row model
  task automatic observe();
    int idx;
    n_cmp++;
    if ($countones(wl) > 1) begin
      n_bad++; $display("FAIL wl_onehot: %0d bits set, required at most 1", $countones(wl));
    end
    idx = wl_index(wl);
    if (idx >= 0) begin
      n_cmp++;
      if (s_ready !== 1'b0) begin n_bad++; $display("FAIL s_ready_in_write: got %b required 0", s_ready); end
      if (pulse_len == 0) begin
        n_cmp++;
        if (idx != rows_written) begin n_bad++; $display("FAIL wl_row: got %0d required %0d", idx, rows_written); end
        n_cmp++;
        if (acc_in_row != WPR) begin n_bad++; $display("FAIL write_entry: words in row %0d required %0d", acc_in_row, WPR); end
        n_cmp++;
        if (bl !== exp_bl) begin n_bad++; $display("FAIL bl_write row %0d: got %h required %h", idx, bl, exp_bl); end
      end
      pulse_len++;
    end else if (pulse_len > 0) begin
      n_cmp++;
      if (pulse_len != WL_PULSE) begin n_bad++; $display("FAIL wl_pulse_len: got %0d required %0d", pulse_len, WL_PULSE); end
      n_cmp++;
      if (bl !== exp_bl) begin n_bad++; $display("FAIL bl_hold row %0d: got %h required %h", rows_written, bl, exp_bl); end
      rows_written++;
      acc_in_row = 0;
      pulse_len  = 0;
    end
  endtask

  // vmode: 0 valid held, 1 valid toggling, 2 random valid.
  // kind: 0 run to done, 1 stop at first WRITE cycle of at_row,
  //       2 stop in LOAD of at_row after 3 words, 3 pulse start in LOAD of at_row.
  task automatic run(input int vmode, input int kind, input int at_row, output bit hit);
    bit hs, v;
    hit = 1'b0;
    for (int n = 0; n < 40000; n++) begin
      observe();
      if (done) begin hit = 1'b1; return; end
      if (kind == 1 && pulse_len == 1 && rows_written == at_row) begin hit = 1'b1; return; end
      if (kind == 2 && rows_written == at_row && acc_in_row == 3 && s_ready) begin hit = 1'b1; return; end
      if (kind == 3 && !start_injected && rows_written == at_row && s_ready) begin
        start = 1'b1; start_injected = 1'b1;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = v ? word_of(total_acc) : DW'($urandom);
      hs      = v && s_ready;
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (hs) model_accept(s_data);
    end
    n_cmp++; n_bad++;
    $display("FAIL run_timeout: no event after 40000 cycles (rows %0d)", rows_written);
  endtask

  task automatic begin_load();
    model_clear();
    start_injected = 1'b0;
    start = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    n_cmp++;
    if ({s_ready, busy, done} !== 3'b110) begin
      n_bad++; $display("FAIL start_enter_load: ready/busy/done got %b required 110", {s_ready, busy, done});
    end
    n_cmp++;
    if (bl !== '0) begin n_bad++; $display("FAIL bl_clear_on_start: got %h required 0", bl); end
  endtask

  task automatic go_idle();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic check_complete(input bit hit, input bit timed);
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL load_done_seen: got 0 required 1"); end
    n_cmp++;
    if (rows_written != NUM_WL) begin n_bad++; $display("FAIL rows_written: got %0d required %0d", rows_written, NUM_WL); end
    n_cmp++;
    if (total_acc != NUM_WL * WPR) begin n_bad++; $display("FAIL words_accepted: got %0d required %0d", total_acc, NUM_WL * WPR); end
    n_cmp++;
    if (bl !== exp_bl) begin n_bad++; $display("FAIL bl_final: got %h required %h", bl, exp_bl); end
    n_cmp++;
    if ({busy, s_ready, wl} !== '0) begin n_bad++; $display("FAIL done_quiet: busy %b ready %b wl_bits %0d", busy, s_ready, $countones(wl)); end
    if (timed) begin
      n_cmp++;
      if (cycles != NUM_WL * (WPR + WL_PULSE + 1) + 1) begin
        n_bad++; $display("FAIL done_latency: got %0d required %0d", cycles, NUM_WL * (WPR + WL_PULSE + 1) + 1);
      end
    end
  endtask

  task automatic test_reset();
    global_resetn = 1'b0;
    start = 0; abort = 0; s_valid = 0; s_data = '0;
    b_start = 0; b_abort = 0; b_s_valid = 0; b_s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({s_ready, busy, done, b_s_ready, b_busy, b_done} !== 6'b0 || wl !== '0 || bl !== '0) begin
      n_bad++; $display("FAIL reset_outputs: ready/busy/done %b%b%b wl %0d bl_ones %0d", s_ready, busy, done, $countones(wl), $countones(bl));
    end
    global_resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({s_ready, busy, done} !== 3'b000) begin n_bad++; $display("FAIL idle_after_reset: got %b required 000", {s_ready, busy, done}); end
  endtask

  // 40-bit rows: upper 24 bits of the second word must be discarded
  task automatic test_narrow_row();
    logic [31:0] w [4];
    logic [0:B_BL-1] e;
    int acc, cyc, plen, row;
    bit hs, seen_done;
    w[0] = 32'hA5A5A5A5; w[1] = 32'h000000FF; w[2] = 32'h5A5A5A5A; w[3] = 32'h123456C3;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_s_valid = 1'b1;
    acc = 0; cyc = 1; plen = 0; row = 0; seen_done = 0;
    for (int n = 0; n < 100 && !seen_done; n++) begin
      if (b_done) begin
        seen_done = 1;
        n_cmp++;
        if (cyc != B_WL * (2 + B_PW + 1) + 1) begin n_bad++; $display("FAIL narrow_done_latency: got %0d required %0d", cyc, B_WL * (2 + B_PW + 1) + 1); end
      end else if (b_wl != '0) begin
        if (plen == 0) begin
          for (int j = 0; j < B_BL; j++) e[j] = (j < 32) ? w[2*row][j] : w[2*row+1][j-32];
          n_cmp++;
          if (b_bl !== e) begin n_bad++; $display("FAIL narrow_bl row %0d: got %h required %h", row, b_bl, e); end
          n_cmp++;
          if (b_wl[row] !== 1'b1) begin n_bad++; $display("FAIL narrow_wl row %0d: got %b", row, b_wl); end
          n_cmp++;
          if (row == 0 && (b_bl[0:31] !== 32'hA5A5A5A5 || b_bl[32:39] !== 8'hFF)) begin
            n_bad++; $display("FAIL narrow_row0_fields: got %h / %h required a5a5a5a5 / ff", b_bl[0:31], b_bl[32:39]);
          end
          if (row == 1 && b_bl[32:39] !== 8'hC3) begin
            n_bad++; $display("FAIL narrow_row1_tail: got %h required c3", b_bl[32:39]);
          end
        end
        plen++;
      end else if (plen > 0) begin
        n_cmp++;
        if (plen != B_PW) begin n_bad++; $display("FAIL narrow_pulse_len: got %0d required %0d", plen, B_PW); end
        plen = 0; row++;
      end
      b_s_data = (acc < 4) ? w[acc] : 32'hDEADBEEF;
      hs = b_s_valid && b_s_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) acc++;
    end
    b_s_valid = 1'b0;
    n_cmp++;
    if (!seen_done || acc != 4) begin n_bad++; $display("FAIL narrow_complete: done %0d words %0d required 1 and 4", seen_done, acc); end
  endtask

  task automatic test_full_load();
    bit hit;
    seed = $urandom;
    begin_load();
    run(0, 0, 0, hit);
    check_complete(hit, 1'b1);
    saved_bl = exp_bl;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL done_sticky: done/busy got %b required 10", {done, busy}); end
  endtask

  task automatic test_valid_toggle();
    bit hit;
    begin_load();
    run(1, 0, 0, hit);
    check_complete(hit, 1'b0);
    n_cmp++;
    if (bl !== saved_bl) begin n_bad++; $display("FAIL toggle_vs_continuous: got %h required %h", bl, saved_bl); end
  endtask

  task automatic test_abort();
    bit hit;
    begin_load();
    run(0, 1, 5, hit);
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL abort_reach_row5: got 0 required 1"); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if (wl !== '0) begin n_bad++; $display("FAIL abort_wl: got %0d bits required 0", $countones(wl)); end
    n_cmp++;
    if ({busy, done, s_ready} !== 3'b000) begin n_bad++; $display("FAIL abort_idle: busy/done/ready got %b required 000", {busy, done, s_ready}); end
    n_cmp++;
    if (bl !== exp_bl) begin n_bad++; $display("FAIL abort_bl_retained: got %h required %h", bl, exp_bl); end
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    n_cmp++;
    if ({busy, s_ready} !== 2'b00) begin n_bad++; $display("FAIL abort_beats_start: busy/ready got %b required 00", {busy, s_ready}); end
    begin_load();
    run(0, 2, 0, hit);
    s_valid = 1'b1; s_data = ~word_of(total_acc); abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    n_cmp++;
    if (bl !== exp_bl || busy !== 1'b0) begin n_bad++; $display("FAIL abort_inflight_dropped: busy %b bl %h required %h", busy, bl, exp_bl); end
    begin_load();
    run(0, 1, 1, hit);
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL reload_after_abort: got 0 required 1"); end
    go_idle();
  endtask

  task automatic test_reset_midload();
    bit hit;
    begin_load();
    run(0, 2, 3, hit);
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL reach_row3_load: got 0 required 1"); end
    s_valid = 1'b1;
    #2 global_resetn = 1'b0;
    #1;
    n_cmp++;
    if ({s_ready, busy, done} !== 3'b000 || wl !== '0 || bl !== '0) begin
      n_bad++; $display("FAIL async_reset: ready/busy/done %b wl %0d bl_ones %0d", {s_ready, busy, done}, $countones(wl), $countones(bl));
    end
    repeat (2) @(posedge clk);
    #1;
    global_resetn = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({s_ready, busy} !== 2'b00) begin n_bad++; $display("FAIL start_on_release: ready/busy got %b required 00", {s_ready, busy}); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin n_bad++; $display("FAIL ready_after_reset: got %b required 0", s_ready); end
    s_valid = 1'b0;
    begin_load();
    go_idle();
  endtask

  task automatic test_start_while_busy();
    bit hit;
    begin_load();
    run(2, 3, 10, hit);
    check_complete(hit, 1'b0);
    begin_load();
    run(0, 1, 1, hit);
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL restart_from_done: got 0 required 1"); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_narrow_row();
    test_full_load();
    test_valid_toggle();
    test_abort();
    test_reset_midload();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
